// File: rtl/ex_wb_retire_pipe_pkg.sv
// Shared definitions for the execute->writeback retire pipeline.
//   NSTAGE_MAX     : largest supported number of retire stages
//   fill_sel_t     : result of the load-fill pointer search
//   oldest_pending : priority encoder picking the oldest stage awaiting load data
package ex_wb_retire_pipe_pkg;

   localparam int unsigned NSTAGE_MAX  = 4;
   localparam int unsigned STAGE_IDX_W = 2;

   typedef struct packed {
      logic                   hit;
      logic [STAGE_IDX_W-1:0] idx;
   } fill_sel_t;

   // Higher index = older stage, so the last set bit wins.
   function automatic fill_sel_t oldest_pending(input logic [NSTAGE_MAX-1:0] pend);
      fill_sel_t sel;
      sel = '0;
      for (int unsigned i = 0; i < NSTAGE_MAX; i++) begin
         if (pend[i]) begin
            sel.hit = 1'b1;
            sel.idx = STAGE_IDX_W'(i);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/ex_wb_retire_pipe_fwd.sv
// Operand forwarding select for one source register.
//   i_addr / i_rf      : decode source address and regfile read data
//   i_valid/i_we/i_ok  : per-stage flags (bit 0 = youngest stage)
//   i_rd / i_data      : per-stage destination and data, flattened
//   o_operand          : forwarded operand
//   o_not_ready        : matching stage still waits for load data
module wb_fwd_select
   import ex_wb_retire_pipe_pkg::*;
#(
   parameter int unsigned NSTAGE = 2,
   parameter int unsigned AWIDTH = 5,
   parameter int unsigned DWIDTH = 32
) (
   input  logic [AWIDTH-1:0]        i_addr,
   input  logic [DWIDTH-1:0]        i_rf,
   input  logic [NSTAGE-1:0]        i_valid,
   input  logic [NSTAGE-1:0]        i_we,
   input  logic [NSTAGE-1:0]        i_ok,
   input  logic [NSTAGE*AWIDTH-1:0] i_rd,
   input  logic [NSTAGE*DWIDTH-1:0] i_data,
   output logic [DWIDTH-1:0]        o_operand,
   output logic                     o_not_ready
);

   logic hit;

   always_comb begin
      o_operand   = i_rf;
      o_not_ready = 1'b0;
      hit         = 1'b0;
      for (int unsigned k = 0; k < NSTAGE; k++) begin
         if (!hit && i_valid[k] && i_we[k] && (i_addr != '0) &&
             (i_rd[k*AWIDTH +: AWIDTH] == i_addr)) begin
            hit = 1'b1;
            if (i_ok[k]) begin
               o_operand = i_data[k*DWIDTH +: DWIDTH];
            end else begin
               o_not_ready = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ex_wb_retire_pipe.sv
// Execute->writeback retire pipeline.
//   fe_clk/fe_rst            : clock, asynchronous active-low reset
//   i_ce..i_pc               : incoming execute result
//   i_mem_valid/i_mem_data   : in-order load data return
//   i_addr_rs*/i_rf_rs*      : decode sources and regfile read data
//   o_op_rs*/o_hazard        : forwarded operands and dependency stall (comb)
//   o_mem_wait               : oldest stage waiting for load data (comb)
//   o_wb_*                   : registered regfile write port
//   o_retire_pc/o_retire_cnt : last retired pc, wrapping retire count
//   o_mem_orphan             : pulse when load data arrives with nothing pending
module ex_wb_retire_pipe
   import ex_wb_retire_pipe_pkg::*;
#(
   parameter int unsigned NSTAGE    = 2,
   parameter int unsigned AWIDTH    = 5,
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 fe_clk,
   input  logic                 fe_rst,
   input  logic                 i_ce,
   input  logic                 i_valid,
   input  logic                 i_flush,
   input  logic                 i_stall,
   input  logic                 i_we,
   input  logic                 i_is_load,
   input  logic [AWIDTH-1:0]    i_addr_rd,
   input  logic [DWIDTH-1:0]    i_data_rd,
   input  logic [PC_WIDTH-1:0]  i_pc,
   input  logic                 i_mem_valid,
   input  logic [DWIDTH-1:0]    i_mem_data,
   input  logic [AWIDTH-1:0]    i_addr_rs1,
   input  logic [AWIDTH-1:0]    i_addr_rs2,
   input  logic [DWIDTH-1:0]    i_rf_rs1,
   input  logic [DWIDTH-1:0]    i_rf_rs2,
   output logic [DWIDTH-1:0]    o_op_rs1,
   output logic [DWIDTH-1:0]    o_op_rs2,
   output logic                 o_hazard,
   output logic                 o_mem_wait,
   output logic                 o_wb_we,
   output logic [AWIDTH-1:0]    o_wb_addr,
   output logic [DWIDTH-1:0]    o_wb_data,
   output logic [PC_WIDTH-1:0]  o_retire_pc,
   output logic [CNT_WIDTH-1:0] o_retire_cnt,
   output logic                 o_mem_orphan
);

   localparam int unsigned IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   logic [NSTAGE-1:0]   valid_q, valid_d, we_q, we_d, ok_q, ok_d;
   logic [AWIDTH-1:0]   rd_q   [NSTAGE];
   logic [AWIDTH-1:0]   rd_d   [NSTAGE];
   logic [DWIDTH-1:0]   data_q [NSTAGE];
   logic [DWIDTH-1:0]   data_d [NSTAGE];
   logic [PC_WIDTH-1:0] pc_q   [NSTAGE];
   logic [PC_WIDTH-1:0] pc_d   [NSTAGE];

   logic                 wb_we_q, wb_we_d;
   logic [AWIDTH-1:0]    wb_addr_q, wb_addr_d;
   logic [DWIDTH-1:0]    wb_data_q, wb_data_d;
   logic [PC_WIDTH-1:0]  retire_pc_q, retire_pc_d;
   logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
   logic                 orphan_q, orphan_d;

   logic                  mem_wait, adv;
   logic [NSTAGE_MAX-1:0] pend_mask;
   fill_sel_t             fill_sel;
   logic [IW-1:0]         fill_tgt;

   always_comb begin
      mem_wait = valid_q[NSTAGE-1] && !ok_q[NSTAGE-1];
      adv      = !i_stall && !mem_wait;

      pend_mask = '0;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
         pend_mask[i] = valid_q[i] && !ok_q[i];
      end
      fill_sel = oldest_pending(pend_mask);
      // The fill pointer is found on the pre-shift stages; the pending stage
      // can never be the last one while advancing, so idx+1 stays in range.
      fill_tgt = IW'(fill_sel.idx) + IW'(adv);

      valid_d = valid_q;
      we_d    = we_q;
      ok_d    = ok_q;
      rd_d    = rd_q;
      data_d  = data_q;
      pc_d    = pc_q;

      if (adv) begin
         for (int unsigned k = 1; k < NSTAGE; k++) begin
            valid_d[k] = valid_q[k-1];
            we_d[k]    = we_q[k-1];
            ok_d[k]    = ok_q[k-1];
            rd_d[k]    = rd_q[k-1];
            data_d[k]  = data_q[k-1];
            pc_d[k]    = pc_q[k-1];
         end
         valid_d[0] = i_ce && i_valid && !i_flush;
         we_d[0]    = i_we;
         ok_d[0]    = !i_is_load;
         rd_d[0]    = i_addr_rd;
         data_d[0]  = i_data_rd;
         pc_d[0]    = i_pc;
      end

      if (i_mem_valid && fill_sel.hit) begin
         data_d[fill_tgt] = i_mem_data;
         ok_d[fill_tgt]   = 1'b1;
      end
      orphan_d = i_mem_valid && !fill_sel.hit;

      wb_we_d      = 1'b0;
      wb_addr_d    = wb_addr_q;
      wb_data_d    = wb_data_q;
      retire_pc_d  = retire_pc_q;
      retire_cnt_d = retire_cnt_q;
      if (adv && valid_q[NSTAGE-1]) begin
         wb_we_d      = we_q[NSTAGE-1] && (rd_q[NSTAGE-1] != '0);
         wb_addr_d    = rd_q[NSTAGE-1];
         wb_data_d    = data_q[NSTAGE-1];
         retire_pc_d  = pc_q[NSTAGE-1];
         retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge fe_clk or negedge fe_rst) begin
      if (!fe_rst) begin
         valid_q <= '0;
         we_q    <= '0;
         ok_q    <= '0;
         for (int unsigned k = 0; k < NSTAGE; k++) begin
            rd_q[k]   <= '0;
            data_q[k] <= '0;
            pc_q[k]   <= '0;
         end
         wb_we_q      <= 1'b0;
         wb_addr_q    <= '0;
         wb_data_q    <= '0;
         retire_pc_q  <= '0;
         retire_cnt_q <= '0;
         orphan_q     <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         we_q         <= we_d;
         ok_q         <= ok_d;
         rd_q         <= rd_d;
         data_q       <= data_d;
         pc_q         <= pc_d;
         wb_we_q      <= wb_we_d;
         wb_addr_q    <= wb_addr_d;
         wb_data_q    <= wb_data_d;
         retire_pc_q  <= retire_pc_d;
         retire_cnt_q <= retire_cnt_d;
         orphan_q     <= orphan_d;
      end
   end

   logic [NSTAGE*AWIDTH-1:0] rd_flat;
   logic [NSTAGE*DWIDTH-1:0] data_flat;

   for (genvar g = 0; g < NSTAGE; g++) begin : g_flat
      assign rd_flat[g*AWIDTH +: AWIDTH]   = rd_q[g];
      assign data_flat[g*DWIDTH +: DWIDTH] = data_q[g];
   end

   logic nr_rs1, nr_rs2;

   wb_fwd_select #(.NSTAGE(NSTAGE), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_fwd_rs1 (
      .i_addr      (i_addr_rs1),
      .i_rf        (i_rf_rs1),
      .i_valid     (valid_q),
      .i_we        (we_q),
      .i_ok        (ok_q),
      .i_rd        (rd_flat),
      .i_data      (data_flat),
      .o_operand   (o_op_rs1),
      .o_not_ready (nr_rs1)
   );

   wb_fwd_select #(.NSTAGE(NSTAGE), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_fwd_rs2 (
      .i_addr      (i_addr_rs2),
      .i_rf        (i_rf_rs2),
      .i_valid     (valid_q),
      .i_we        (we_q),
      .i_ok        (ok_q),
      .i_rd        (rd_flat),
      .i_data      (data_flat),
      .o_operand   (o_op_rs2),
      .o_not_ready (nr_rs2)
   );

   assign o_hazard     = nr_rs1 || nr_rs2;
   assign o_mem_wait   = mem_wait;
   assign o_wb_we      = wb_we_q;
   assign o_wb_addr    = wb_addr_q;
   assign o_wb_data    = wb_data_q;
   assign o_retire_pc  = retire_pc_q;
   assign o_retire_cnt = retire_cnt_q;
   assign o_mem_orphan = orphan_q;

endmodule

// File: tb/tb_ex_wb_retire_pipe.sv
// Self-checking bench for ex_wb_retire_pipe (NSTAGE=2, narrow retire counter).
// Reference model: a queue of in-flight results tagged with their age;
// retired results go to a scoreboard that a separate monitor drains.
module tb_ex_wb_retire_pipe;

   localparam int unsigned NS = 2;
   localparam int unsigned CW = 8;

   logic        fe_clk = 1'b0;
   logic        fe_rst;
   logic        i_ce, i_valid, i_flush, i_stall, i_we, i_is_load;
   logic [4:0]  i_addr_rd, i_addr_rs1, i_addr_rs2;
   logic [31:0] i_data_rd, i_pc, i_mem_data, i_rf_rs1, i_rf_rs2;
   logic        i_mem_valid;
   logic [31:0] o_op_rs1, o_op_rs2, o_wb_data, o_retire_pc;
   logic        o_hazard, o_mem_wait, o_wb_we, o_mem_orphan;
   logic [4:0]  o_wb_addr;
   logic [CW-1:0] o_retire_cnt;

   ex_wb_retire_pipe #(.NSTAGE(NS), .AWIDTH(5), .DWIDTH(32), .PC_WIDTH(32), .CNT_WIDTH(CW)) dut (
      .fe_clk(fe_clk), .fe_rst(fe_rst), .i_ce(i_ce), .i_valid(i_valid), .i_flush(i_flush),
      .i_stall(i_stall), .i_we(i_we), .i_is_load(i_is_load), .i_addr_rd(i_addr_rd),
      .i_data_rd(i_data_rd), .i_pc(i_pc), .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data),
      .i_addr_rs1(i_addr_rs1), .i_addr_rs2(i_addr_rs2), .i_rf_rs1(i_rf_rs1), .i_rf_rs2(i_rf_rs2),
      .o_op_rs1(o_op_rs1), .o_op_rs2(o_op_rs2), .o_hazard(o_hazard), .o_mem_wait(o_mem_wait),
      .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_retire_pc(o_retire_pc),
      .o_retire_cnt(o_retire_cnt), .o_mem_orphan(o_mem_orphan)
   );

   always #5 fe_clk = ~fe_clk;

   typedef struct {
      int unsigned age;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        ok;
      logic [31:0] pc;
   } ent_t;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pc;
   } ret_t;

   ent_t pipe[$];
   ret_t expq[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic exp_orphan = 1'b0;
   logic mon_resync = 1'b1;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic model_mw();
      foreach (pipe[j]) if (pipe[j].age == NS - 1 && !pipe[j].ok) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_fwd(input logic [4:0] a, input logic [31:0] rf,
                                     output logic [31:0] op, output logic hz);
      int best;
      best = -1;
      op = rf;
      hz = 1'b0;
      if (a == 5'd0) return;
      foreach (pipe[j]) begin
         if (pipe[j].we && pipe[j].rd == a && (best < 0 || pipe[j].age < pipe[best].age)) best = j;
      end
      if (best >= 0) begin
         if (pipe[best].ok) op = pipe[best].data;
         else hz = 1'b1;
      end
   endfunction

   function automatic void model_edge();
      logic adv;
      int   idx;
      ent_t e;
      ret_t r;
      adv = !i_stall && !model_mw();
      exp_orphan = 1'b0;
      if (i_mem_valid) begin
         idx = -1;
         foreach (pipe[j]) if (!pipe[j].ok && (idx < 0 || pipe[j].age > pipe[idx].age)) idx = j;
         if (idx < 0) exp_orphan = 1'b1;
         else begin
            pipe[idx].data = i_mem_data;
            pipe[idx].ok   = 1'b1;
         end
      end
      if (adv) begin
         foreach (pipe[j]) pipe[j].age++;
         for (int j = pipe.size() - 1; j >= 0; j--) begin
            if (pipe[j].age >= NS) begin
               r.we   = pipe[j].we && (pipe[j].rd != 5'd0);
               r.addr = pipe[j].rd;
               r.data = pipe[j].data;
               r.pc   = pipe[j].pc;
               expq.push_back(r);
               pipe.delete(j);
            end
         end
         if (i_ce && i_valid && !i_flush) begin
            e.age = 0; e.we = i_we; e.rd = i_addr_rd; e.data = i_data_rd;
            e.ok = !i_is_load; e.pc = i_pc;
            pipe.push_front(e);
         end
      end
   endfunction

   task automatic clr_in();
      i_ce = 0; i_valid = 1; i_flush = 0; i_stall = 0; i_we = 0; i_is_load = 0;
      i_addr_rd = 0; i_data_rd = 0; i_pc = 0; i_mem_valid = 0; i_mem_data = 0;
      i_addr_rs1 = 0; i_addr_rs2 = 0; i_rf_rs1 = $urandom; i_rf_rs2 = $urandom;
   endtask

   task automatic issue(input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic ld, input logic [31:0] pc);
      i_ce = 1; i_valid = 1; i_we = we; i_addr_rd = rd; i_data_rd = data; i_is_load = ld; i_pc = pc;
   endtask

   // One clock: combinational checks at negedge, model update at posedge.
   task automatic step();
      logic [31:0] op1, op2;
      logic        h1, h2;
      @(negedge fe_clk);
      model_fwd(i_addr_rs1, i_rf_rs1, op1, h1);
      model_fwd(i_addr_rs2, i_rf_rs2, op2, h2);
      chk("op_rs1", o_op_rs1, op1);
      chk("op_rs2", o_op_rs2, op2);
      chk("hazard", o_hazard, h1 | h2);
      chk("mem_wait", o_mem_wait, model_mw());
      @(posedge fe_clk);
      model_edge();
      #1;
      chk("mem_orphan", o_mem_orphan, exp_orphan);
   endtask

   initial begin : monitor
      logic [CW-1:0] last;
      ret_t r;
      last = '0;
      forever begin
         @(posedge fe_clk);
         #1;
         if (!fe_rst || mon_resync) begin
            if (fe_rst) begin
               chk("cnt_after_reset", o_retire_cnt, 0);
               chk("wb_we_after_reset", o_wb_we, 0);
               mon_resync = 1'b0;
            end
            last = o_retire_cnt;
            continue;
         end
         if (o_retire_cnt !== last) begin
            if (expq.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_retire: cnt 0x%0h with no expected result at %0t", o_retire_cnt, $time);
            end else begin
               r = expq.pop_front();
               chk("wb_we", o_wb_we, r.we);
               chk("wb_addr", o_wb_addr, r.addr);
               chk("wb_data", o_wb_data, r.data);
               chk("retire_pc", o_retire_pc, r.pc);
               chk("retire_cnt_step", o_retire_cnt, CW'(last + 1'b1));
            end
            last = o_retire_cnt;
         end else begin
            chk("wb_we_idle", o_wb_we, 0);
         end
      end
   end

   initial begin : driver
      fe_rst = 1'b0;
      clr_in();
      repeat (2) @(posedge fe_clk);
      #1;
      chk("rst_wb_we", o_wb_we, 0);
      chk("rst_wb_addr", o_wb_addr, 0);
      chk("rst_wb_data", o_wb_data, 0);
      chk("rst_retire_pc", o_retire_pc, 0);
      chk("rst_retire_cnt", o_retire_cnt, 0);
      chk("rst_mem_wait", o_mem_wait, 0);
      @(negedge fe_clk);
      fe_rst = 1'b1;
      @(posedge fe_clk);
      #1;

      // ALU chain
      clr_in(); issue(1, 5'd5, 32'h11, 0, 32'h100); step();
      clr_in(); i_addr_rs1 = 5'd5; i_rf_rs1 = 32'hAAAA_5555; #1;
      chk("alu_fwd_rs1", o_op_rs1, 32'h11);
      chk("alu_fwd_hazard", o_hazard, 0);
      step();
      chk("alu_wb_early", o_wb_we, 0);
      step();
      chk("alu_wb_we", o_wb_we, 1);
      chk("alu_wb_addr", o_wb_addr, 5);
      chk("alu_wb_data", o_wb_data, 32'h11);
      chk("alu_cnt", o_retire_cnt, 1);

      // Load-use and memory freeze
      clr_in(); issue(1, 5'd7, 32'h1234, 1, 32'h104); step();
      clr_in(); i_addr_rs2 = 5'd7; i_rf_rs2 = 32'h5555; #1;
      chk("load_use_hazard", o_hazard, 1);
      chk("load_use_op", o_op_rs2, 32'h5555);
      step();
      chk("freeze_mem_wait", o_mem_wait, 1);
      issue(1, 5'd9, 32'h99, 0, 32'h108);
      repeat (2) step();
      i_ce = 0;
      chk("freeze_cnt", o_retire_cnt, 1);
      chk("freeze_hazard", o_hazard, 1);
      i_mem_valid = 1; i_mem_data = 32'hDEADBEEF; step();
      i_mem_valid = 0; #1;
      chk("fill_mem_wait", o_mem_wait, 0);
      chk("fill_hazard", o_hazard, 0);
      chk("fill_op_rs2", o_op_rs2, 32'hDEADBEEF);
      step();
      chk("load_wb_addr", o_wb_addr, 7);
      chk("load_wb_data", o_wb_data, 32'hDEADBEEF);
      chk("load_cnt", o_retire_cnt, 2);

      // Flush and stall
      clr_in(); issue(1, 5'd9, 32'h99, 0, 32'h10C); i_flush = 1; step();
      clr_in(); repeat (3) step();
      chk("flush_cnt", o_retire_cnt, 2);
      clr_in(); issue(1, 5'd0, 32'h77, 0, 32'h200); step();
      clr_in(); issue(1, 5'd3, 32'h33, 0, 32'h204); step();
      clr_in(); i_stall = 1; i_addr_rs1 = 5'd3; repeat (4) step();
      chk("stall_cnt", o_retire_cnt, 2);
      chk("stall_fwd", o_op_rs1, 32'h33);
      clr_in(); step();
      chk("x0_wb_we", o_wb_we, 0);
      chk("x0_cnt", o_retire_cnt, 3);
      step();
      chk("x3_wb_we", o_wb_we, 1);
      chk("x3_cnt", o_retire_cnt, 4);
      step();

      // Orphan load data
      clr_in(); i_mem_valid = 1; i_mem_data = 32'hBAD; step();
      chk("orphan_pulse", o_mem_orphan, 1);
      clr_in(); step();
      chk("orphan_clear", o_mem_orphan, 0);

      // Randomised traffic
      for (int unsigned n = 0; n < 500; n++) begin
         clr_in();
         i_ce        = ($urandom_range(0, 9) < 7);
         i_valid     = ($urandom_range(0, 9) != 0);
         i_flush     = ($urandom_range(0, 9) == 0);
         i_stall     = ($urandom_range(0, 19) < 3);
         i_we        = ($urandom_range(0, 9) < 8);
         i_is_load   = ($urandom_range(0, 9) < 3);
         i_addr_rd   = 5'($urandom_range(0, 7));
         i_data_rd   = $urandom;
         i_pc        = $urandom;
         i_mem_valid = ($urandom_range(0, 9) < 3);
         i_mem_data  = $urandom;
         i_addr_rs1  = 5'($urandom_range(0, 7));
         i_addr_rs2  = 5'($urandom_range(0, 7));
         step();
      end
      for (int unsigned n = 0; n < 20 && pipe.size() > 0; n++) begin
         clr_in(); i_mem_valid = 1; i_mem_data = $urandom; step();
      end
      chk("random_drained", pipe.size(), 0);

      // Reset with two entries in flight
      clr_in(); issue(1, 5'd4, 32'h44, 0, 32'h300); step();
      clr_in(); issue(1, 5'd6, 32'h66, 1, 32'h304); step();
      clr_in(); i_addr_rs1 = 5'd4; i_rf_rs1 = 32'h0F0F_0F0F;
      #1;
      fe_rst = 1'b0;
      mon_resync = 1'b1;
      pipe.delete();
      expq.delete();
      #1;
      chk("mid_rst_wb_we", o_wb_we, 0);
      chk("mid_rst_cnt", o_retire_cnt, 0);
      chk("mid_rst_pc", o_retire_pc, 0);
      chk("mid_rst_wb_data", o_wb_data, 0);
      chk("mid_rst_mem_wait", o_mem_wait, 0);
      chk("mid_rst_op_rs1", o_op_rs1, 32'h0F0F_0F0F);
      @(negedge fe_clk);
      fe_rst = 1'b1;
      @(posedge fe_clk);
      #1;
      repeat (4) step();
      chk("post_rst_cnt", o_retire_cnt, 0);

      // Counter wrap: 2^CW + 1 retires
      for (int unsigned n = 0; n < (1 << CW) + 1; n++) begin
         clr_in(); issue(1, 5'($urandom_range(1, 7)), $urandom, 0, 32'(n * 4)); step();
      end
      clr_in(); repeat (3) step();
      chk("wrap_cnt", o_retire_cnt, 1);

      #2;
      chk("scoreboard_empty", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
